// File: rtl/master_start_seq.sv
`default_nettype none
// ============================================================================
// Module   : master_start_seq
// Brief    : Timed radar pulse-train sequencer with 1 Hz time resync and a
//            command FIFO whose entries execute back-to-back.
// Revision : 1.0
// ============================================================================
module master_start_seq #(
    parameter int TIME_W      = 64,
    parameter int FREQ_W      = 48,
    parameter int RATE_W      = 32,
    parameter int INT_W       = 32,
    parameter int NCNT_W      = 16,
    parameter int DEPTH       = 4,
    parameter int LATE_POLICY = 0
) (
    input  logic                      CLK,
    input  logic                      RESET_N,
    input  logic [TIME_W-1:0]         SYS_TIME,
    input  logic                      SYS_TIME_UPDATE,
    input  logic                      T1hz,
    output logic                      SYS_TIME_UPDATE_OK,
    output logic [TIME_W-1:0]         TIME_NOW,
    input  logic                      CMD_WR,
    input  logic [FREQ_W-1:0]         CMD_FREQ,
    input  logic [FREQ_W-1:0]         CMD_DFREQ,
    input  logic [RATE_W-1:0]         CMD_DRATE,
    input  logic [TIME_W-1:0]         CMD_TSTART,
    input  logic [NCNT_W-1:0]         CMD_N,
    input  logic                      CMD_COH,
    input  logic [INT_W-1:0]          CMD_TBL1,
    input  logic [INT_W-1:0]          CMD_TIZ,
    input  logic [INT_W-1:0]          CMD_TBL2,
    input  logic [INT_W-1:0]          CMD_TPR,
    input  logic                      ABORT,
    output logic                      CMD_FULL,
    output logic [$clog2(DEPTH):0]    FIFO_LEVEL,
    output logic                      CMD_OVF,
    output logic                      CMD_LATE,
    output logic                      CMD_DONE,
    output logic                      ABORTED,
    output logic                      BUSY,
    output logic [FREQ_W-1:0]         DDS_freq,
    output logic [FREQ_W-1:0]         DDS_delta_freq,
    output logic [RATE_W-1:0]         DDS_delta_rate,
    output logic                      DDS_start,
    output logic                      En_Iz,
    output logic                      En_Pr
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [FREQ_W-1:0] freq;
        logic [FREQ_W-1:0] dfreq;
        logic [RATE_W-1:0] drate;
        logic [TIME_W-1:0] tstart;
        logic [NCNT_W-1:0] n;
        logic              coh;
        logic [INT_W-1:0]  tbl1;
        logic [INT_W-1:0]  tiz;
        logic [INT_W-1:0]  tbl2;
        logic [INT_W-1:0]  tpr;
    } cmd_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_WAIT = 3'd2,
        S_BL1  = 3'd3,
        S_IZ   = 3'd4,
        S_BL2  = 3'd5,
        S_PR   = 3'd6,
        S_NEXT = 3'd7
    } state_t;

    // ------------------------------------------------------------------------
    // System time and 1 Hz resynchronisation
    // ------------------------------------------------------------------------
    logic t1_s1, t1_s2, t1_d, upd_d, arm, mark, reload;

    assign mark   = t1_s2 & ~t1_d;
    assign reload = mark & arm;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            t1_s1              <= 1'b0;
            t1_s2              <= 1'b0;
            t1_d               <= 1'b0;
            upd_d              <= 1'b0;
            arm                <= 1'b0;
            SYS_TIME_UPDATE_OK <= 1'b0;
            TIME_NOW           <= '0;
        end else begin
            t1_s1              <= T1hz;
            t1_s2              <= t1_s1;
            t1_d               <= t1_s2;
            upd_d              <= SYS_TIME_UPDATE;
            SYS_TIME_UPDATE_OK <= reload;
            TIME_NOW           <= reload ? SYS_TIME : TIME_NOW + TIME_W'(1);
            // A fresh arm request in the load cycle survives for the next mark
            if (reload)
                arm <= 1'b0;
            if (SYS_TIME_UPDATE && !upd_d)
                arm <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------------
    cmd_t          mem [DEPTH];
    cmd_t          wr_cmd, head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   level;
    logic          full, push, pop;
    state_t        state, nxt;

    assign wr_cmd     = '{freq: CMD_FREQ, dfreq: CMD_DFREQ, drate: CMD_DRATE,
                          tstart: CMD_TSTART, n: CMD_N, coh: CMD_COH,
                          tbl1: CMD_TBL1, tiz: CMD_TIZ, tbl2: CMD_TBL2, tpr: CMD_TPR};
    assign head       = mem[rd_ptr];
    assign full       = (level == (AW+1)'(DEPTH));
    assign push       = CMD_WR & (ABORT | ~full);
    assign pop        = (state == S_LOAD) & ~ABORT;
    assign CMD_FULL   = full;
    assign FIFO_LEVEL = level;

    always_ff @(posedge CLK) begin
        if (push)
            mem[ABORT ? '0 : wr_ptr] <= wr_cmd;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (ABORT) begin
            // Flush, then let a simultaneous write land in the emptied FIFO
            rd_ptr <= '0;
            wr_ptr <= push ? AW'(1) : '0;
            level  <= push ? (AW+1)'(1) : '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    logic [FREQ_W-1:0] freq, dfreq;
    logic [RATE_W-1:0] drate;
    logic [TIME_W-1:0] tstart;
    logic [NCNT_W-1:0] n_rem;
    logic              coh;
    logic [INT_W-1:0]  tbl1, tiz, tbl2, tpr, cnt, dur;
    logic              late, final_pulse, cnt_done;
    state_t            ent0, ent1, ent2, ent3;

    // entN is the first phase at or after position N with a non-zero length
    always_comb begin
        ent3        = (tpr  != '0) ? S_PR  : S_NEXT;
        ent2        = (tbl2 != '0) ? S_BL2 : ent3;
        ent1        = (tiz  != '0) ? S_IZ  : ent2;
        ent0        = (tbl1 != '0) ? S_BL1 : ent1;
        late        = (head.tstart < TIME_NOW);
        final_pulse = (n_rem <= NCNT_W'(1));
        cnt_done    = (cnt == '0);
        nxt         = state;
        case (state)
            S_IDLE: if (level != '0) nxt = S_LOAD;
            S_LOAD: nxt = (late && LATE_POLICY == 0) ? S_IDLE : S_WAIT;
            S_WAIT: if (TIME_NOW >= tstart) nxt = (n_rem == '0) ? S_NEXT : ent0;
            S_BL1:  if (cnt_done) nxt = ent1;
            S_IZ:   if (cnt_done) nxt = ent2;
            S_BL2:  if (cnt_done) nxt = ent3;
            S_PR:   if (cnt_done) nxt = S_NEXT;
            S_NEXT: nxt = final_pulse ? ((level != '0) ? S_LOAD : S_IDLE) : ent0;
            default: nxt = S_IDLE;
        endcase
        if (ABORT)
            nxt = S_IDLE;
        case (nxt)
            S_BL1:   dur = tbl1;
            S_IZ:    dur = tiz;
            S_BL2:   dur = tbl2;
            S_PR:    dur = tpr;
            default: dur = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state          <= S_IDLE;
            cnt            <= '0;
            n_rem          <= '0;
            coh            <= 1'b0;
            freq           <= '0;
            dfreq          <= '0;
            drate          <= '0;
            tstart         <= '0;
            tbl1           <= '0;
            tiz            <= '0;
            tbl2           <= '0;
            tpr            <= '0;
            CMD_OVF        <= 1'b0;
            CMD_LATE       <= 1'b0;
            CMD_DONE       <= 1'b0;
            ABORTED        <= 1'b0;
            BUSY           <= 1'b0;
            DDS_freq       <= '0;
            DDS_delta_freq <= '0;
            DDS_delta_rate <= '0;
            DDS_start      <= 1'b0;
            En_Iz          <= 1'b0;
            En_Pr          <= 1'b0;
        end else begin
            state    <= nxt;
            CMD_OVF  <= CMD_WR & full & ~ABORT;
            CMD_LATE <= pop & late;
            CMD_DONE <= (state == S_NEXT) & final_pulse & ~ABORT;
            ABORTED  <= ABORT & (state != S_IDLE);
            BUSY     <= (nxt != S_IDLE);
            En_Iz    <= (nxt == S_IZ);
            En_Pr    <= (nxt == S_PR);
            // Coherent trains keep the DDS running until the final NEXT
            if (coh)
                DDS_start <= (nxt == S_IZ) |
                             (DDS_start & ((nxt inside {S_BL1, S_IZ, S_BL2, S_PR}) |
                                           ((nxt == S_NEXT) & ~final_pulse)));
            else
                DDS_start <= (nxt == S_IZ);

            if (nxt != state)
                cnt <= dur - INT_W'(1);
            else if (!cnt_done)
                cnt <= cnt - INT_W'(1);

            if (pop) begin
                freq   <= head.freq;
                dfreq  <= head.dfreq;
                drate  <= head.drate;
                tstart <= head.tstart;
                n_rem  <= head.n;
                coh    <= head.coh;
                tbl1   <= head.tbl1;
                tiz    <= head.tiz;
                tbl2   <= head.tbl2;
                tpr    <= head.tpr;
            end else if (state == S_NEXT && n_rem != '0) begin
                n_rem <= n_rem - NCNT_W'(1);
            end

            if (state == S_WAIT && nxt != S_WAIT && !ABORT) begin
                DDS_freq       <= freq;
                DDS_delta_freq <= dfreq;
                DDS_delta_rate <= drate;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_master_start_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_master_start_seq
// Brief    : Directed self-checking bench for master_start_seq.
// Revision : 1.0
// ============================================================================
module tb_master_start_seq;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [63:0] SYS_TIME;
    logic        SYS_TIME_UPDATE, T1hz, SYS_TIME_UPDATE_OK;
    logic [63:0] TIME_NOW;
    logic        CMD_WR, CMD_COH, ABORT;
    logic [47:0] CMD_FREQ, CMD_DFREQ;
    logic [31:0] CMD_DRATE;
    logic [63:0] CMD_TSTART;
    logic [15:0] CMD_N;
    logic [31:0] CMD_TBL1, CMD_TIZ, CMD_TBL2, CMD_TPR;
    logic        CMD_FULL, CMD_OVF, CMD_LATE, CMD_DONE, ABORTED, BUSY;
    logic [2:0]  FIFO_LEVEL;
    logic [47:0] DDS_freq, DDS_delta_freq;
    logic [31:0] DDS_delta_rate;
    logic        DDS_start, En_Iz, En_Pr;

    master_start_seq dut (
        .CLK(CLK), .RESET_N(RESET_N), .SYS_TIME(SYS_TIME),
        .SYS_TIME_UPDATE(SYS_TIME_UPDATE), .T1hz(T1hz),
        .SYS_TIME_UPDATE_OK(SYS_TIME_UPDATE_OK), .TIME_NOW(TIME_NOW),
        .CMD_WR(CMD_WR), .CMD_FREQ(CMD_FREQ), .CMD_DFREQ(CMD_DFREQ),
        .CMD_DRATE(CMD_DRATE), .CMD_TSTART(CMD_TSTART), .CMD_N(CMD_N),
        .CMD_COH(CMD_COH), .CMD_TBL1(CMD_TBL1), .CMD_TIZ(CMD_TIZ),
        .CMD_TBL2(CMD_TBL2), .CMD_TPR(CMD_TPR), .ABORT(ABORT),
        .CMD_FULL(CMD_FULL), .FIFO_LEVEL(FIFO_LEVEL), .CMD_OVF(CMD_OVF),
        .CMD_LATE(CMD_LATE), .CMD_DONE(CMD_DONE), .ABORTED(ABORTED),
        .BUSY(BUSY), .DDS_freq(DDS_freq), .DDS_delta_freq(DDS_delta_freq),
        .DDS_delta_rate(DDS_delta_rate), .DDS_start(DDS_start),
        .En_Iz(En_Iz), .En_Pr(En_Pr)
    );

    always #5 CLK = ~CLK;

    int          vectors = 0;
    int          miscompares = 0;
    logic [63:0] model_time = 64'd0;

    // Activity collected by observe()
    int          iz_cnt, pr_cnt, ds_cnt, ds_neq, done_cnt, late_cnt, ok_cnt;
    int          iz_rises, pr_rises, ds_rises;
    logic [63:0] iz_first, iz_second, pr_first, ds_first;

    task automatic tick();
        @(posedge CLK);
        #1;
        model_time = model_time + 64'd1;
    endtask

    task automatic set_cmd(input logic [63:0] ts, input int n, input logic coh,
                           input int b1, input int iz, input int b2, input int pr,
                           input logic [47:0] f);
        CMD_FREQ   = f;
        CMD_DFREQ  = f + 48'd1;
        CMD_DRATE  = 32'h0000_5A5A;
        CMD_TSTART = ts;
        CMD_N      = 16'(n);
        CMD_COH    = coh;
        CMD_TBL1   = 32'(b1);
        CMD_TIZ    = 32'(iz);
        CMD_TBL2   = 32'(b2);
        CMD_TPR    = 32'(pr);
    endtask

    task automatic push(input logic [63:0] ts, input int n, input logic coh,
                        input int b1, input int iz, input int b2, input int pr,
                        input logic [47:0] f);
        set_cmd(ts, n, coh, b1, iz, b2, pr, f);
        CMD_WR = 1'b1;
        tick();
        CMD_WR = 1'b0;
    endtask

    task automatic observe(input int ncyc);
        logic piz, ppr, pds;
        piz = En_Iz; ppr = En_Pr; pds = DDS_start;
        iz_cnt = 0; pr_cnt = 0; ds_cnt = 0; ds_neq = 0; done_cnt = 0;
        late_cnt = 0; ok_cnt = 0; iz_rises = 0; pr_rises = 0; ds_rises = 0;
        iz_first = '0; iz_second = '0; pr_first = '0; ds_first = '0;
        for (int i = 0; i < ncyc; i++) begin
            tick();
            if (En_Iz) iz_cnt++;
            if (En_Pr) pr_cnt++;
            if (DDS_start) ds_cnt++;
            if (DDS_start !== En_Iz) ds_neq++;
            if (CMD_DONE) done_cnt++;
            if (CMD_LATE) late_cnt++;
            if (SYS_TIME_UPDATE_OK) ok_cnt++;
            if (En_Iz && !piz) begin
                iz_rises++;
                if (iz_rises == 1) iz_first = model_time;
                if (iz_rises == 2) iz_second = model_time;
            end
            if (En_Pr && !ppr) begin
                pr_rises++;
                if (pr_rises == 1) pr_first = model_time;
            end
            if (DDS_start && !pds) begin
                ds_rises++;
                if (ds_rises == 1) ds_first = model_time;
            end
            piz = En_Iz; ppr = En_Pr; pds = DDS_start;
        end
    endtask

    task automatic test_reset();
        RESET_N = 1'b0; SYS_TIME = '0; SYS_TIME_UPDATE = 1'b0; T1hz = 1'b0;
        CMD_WR = 1'b0; ABORT = 1'b0;
        set_cmd(64'd0, 0, 1'b0, 0, 0, 0, 0, 48'd0);
        repeat (3) tick();
        vectors++; if (TIME_NOW !== 64'd0) begin miscompares++; $display("FAIL reset_time got %0d expected 0", TIME_NOW); end
        vectors++; if ({BUSY, FIFO_LEVEL, CMD_FULL, En_Iz, En_Pr, DDS_start, SYS_TIME_UPDATE_OK} !== 9'd0) begin
            miscompares++; $display("FAIL reset_flags got %b expected 0", {BUSY, FIFO_LEVEL, CMD_FULL, En_Iz, En_Pr, DDS_start, SYS_TIME_UPDATE_OK}); end
        vectors++; if (DDS_freq !== 48'd0) begin miscompares++; $display("FAIL reset_dds_freq got %0d expected 0", DDS_freq); end
        RESET_N = 1'b1;
        model_time = 64'd0;
        tick();
        vectors++; if (TIME_NOW !== 64'd1) begin miscompares++; $display("FAIL time_first_inc got %0d expected 1", TIME_NOW); end
    endtask

    task automatic test_time_load();
        SYS_TIME = 64'd1000; SYS_TIME_UPDATE = 1'b1;
        tick(); tick();
        T1hz = 1'b1;
        tick(); tick();
        vectors++; if (SYS_TIME_UPDATE_OK !== 1'b0) begin miscompares++; $display("FAIL ok_early got %b expected 0", SYS_TIME_UPDATE_OK); end
        tick();
        model_time = 64'd1000;
        vectors++; if (TIME_NOW !== 64'd1000) begin miscompares++; $display("FAIL time_load got %0d expected 1000", TIME_NOW); end
        vectors++; if (SYS_TIME_UPDATE_OK !== 1'b1) begin miscompares++; $display("FAIL ok_pulse got %b expected 1", SYS_TIME_UPDATE_OK); end
        tick();
        vectors++; if (SYS_TIME_UPDATE_OK !== 1'b0) begin miscompares++; $display("FAIL ok_width got %b expected 0", SYS_TIME_UPDATE_OK); end
        vectors++; if (TIME_NOW !== 64'd1001) begin miscompares++; $display("FAIL time_after_load got %0d expected 1001", TIME_NOW); end
        T1hz = 1'b0;
        repeat (5) tick();
        T1hz = 1'b1;
        observe(8);
        vectors++; if (ok_cnt !== 0) begin miscompares++; $display("FAIL unarmed_mark ok pulses got %0d expected 0", ok_cnt); end
        vectors++; if (TIME_NOW !== model_time) begin miscompares++; $display("FAIL unarmed_time got %0d expected %0d", TIME_NOW, model_time); end
        T1hz = 1'b0; SYS_TIME_UPDATE = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_incoherent();
        logic [63:0] ts;
        ts = model_time + 64'd20;
        push(ts, 2, 1'b0, 3, 5, 2, 4, 48'h1234_5678_9ABC);
        observe(60);
        vectors++; if (iz_cnt !== 10 || iz_rises !== 2) begin miscompares++; $display("FAIL inc_iz got cnt %0d rises %0d expected 10/2", iz_cnt, iz_rises); end
        vectors++; if (iz_first !== ts + 64'd4) begin miscompares++; $display("FAIL inc_iz_start got %0d expected %0d", iz_first, ts + 64'd4); end
        vectors++; if (iz_second - iz_first !== 64'd15) begin miscompares++; $display("FAIL inc_period got %0d expected 15", iz_second - iz_first); end
        vectors++; if (ds_neq !== 0) begin miscompares++; $display("FAIL inc_dds_eq_iz got %0d differing cycles expected 0", ds_neq); end
        vectors++; if (pr_cnt !== 8 || pr_first !== ts + 64'd11) begin miscompares++; $display("FAIL inc_pr got cnt %0d at %0d expected 8 at %0d", pr_cnt, pr_first, ts + 64'd11); end
        vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL inc_done got %0d expected 1", done_cnt); end
        vectors++; if (DDS_freq !== 48'h1234_5678_9ABC || DDS_delta_freq !== 48'h1234_5678_9ABD || DDS_delta_rate !== 32'h5A5A) begin
            miscompares++; $display("FAIL inc_dds_values got %h/%h/%h expected 123456789abc/123456789abd/5a5a", DDS_freq, DDS_delta_freq, DDS_delta_rate); end
        vectors++; if (BUSY !== 1'b0) begin miscompares++; $display("FAIL inc_idle got %b expected 0", BUSY); end
    endtask

    task automatic test_coherent();
        logic [63:0] ts;
        ts = model_time + 64'd20;
        push(ts, 2, 1'b1, 3, 5, 2, 4, 48'd77);
        observe(60);
        vectors++; if (ds_cnt !== 26 || ds_rises !== 1) begin miscompares++; $display("FAIL coh_dds got cnt %0d rises %0d expected 26/1", ds_cnt, ds_rises); end
        vectors++; if (ds_first !== ts + 64'd4) begin miscompares++; $display("FAIL coh_dds_start got %0d expected %0d", ds_first, ts + 64'd4); end
        vectors++; if (iz_cnt !== 10 || done_cnt !== 1) begin miscompares++; $display("FAIL coh_iz_done got %0d/%0d expected 10/1", iz_cnt, done_cnt); end
    endtask

    task automatic test_fifo_full_abort();
        push(model_time + 64'd100000, 1, 1'b0, 1, 1, 1, 1, 48'd5);
        repeat (3) tick();
        vectors++; if (FIFO_LEVEL !== 3'd0 || BUSY !== 1'b1) begin miscompares++; $display("FAIL ff_waiting got level %0d busy %b expected 0/1", FIFO_LEVEL, BUSY); end
        CMD_WR = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            vectors++;
            if (i <= 4 && (int'(FIFO_LEVEL) !== i || CMD_OVF !== 1'b0)) begin
                miscompares++; $display("FAIL ff_write%0d got level %0d ovf %b expected %0d/0", i, FIFO_LEVEL, CMD_OVF, i); end
            if (i == 5 && (FIFO_LEVEL !== 3'd4 || CMD_FULL !== 1'b1 || CMD_OVF !== 1'b1)) begin
                miscompares++; $display("FAIL ff_overflow got level %0d full %b ovf %b expected 4/1/1", FIFO_LEVEL, CMD_FULL, CMD_OVF); end
        end
        CMD_WR = 1'b0;
        tick();
        vectors++; if (CMD_OVF !== 1'b0 || FIFO_LEVEL !== 3'd4) begin miscompares++; $display("FAIL ff_ovf_width got ovf %b level %0d expected 0/4", CMD_OVF, FIFO_LEVEL); end
        ABORT = 1'b1; CMD_WR = 1'b1;
        tick();
        CMD_WR = 1'b0;
        vectors++; if (FIFO_LEVEL !== 3'd1 || ABORTED !== 1'b1 || BUSY !== 1'b0 || CMD_FULL !== 1'b0) begin
            miscompares++; $display("FAIL abort_wr got level %0d aborted %b busy %b full %b expected 1/1/0/0", FIFO_LEVEL, ABORTED, BUSY, CMD_FULL); end
        tick();
        ABORT = 1'b0;
        vectors++; if (FIFO_LEVEL !== 3'd0 || ABORTED !== 1'b0) begin miscompares++; $display("FAIL abort_idle got level %0d aborted %b expected 0/0", FIFO_LEVEL, ABORTED); end
        tick();
        vectors++; if (BUSY !== 1'b0) begin miscompares++; $display("FAIL abort_stays_idle got %b expected 0", BUSY); end
    endtask

    task automatic test_late();
        logic [63:0] ts;
        push(model_time - 64'd10, 1, 1'b0, 1, 2, 1, 1, 48'd9);
        ts = model_time + 64'd20;
        push(ts, 1, 1'b0, 2, 3, 1, 2, 48'd10);
        observe(50);
        vectors++; if (late_cnt !== 1) begin miscompares++; $display("FAIL late_pulse got %0d expected 1", late_cnt); end
        vectors++; if (iz_rises !== 1 || iz_cnt !== 3 || iz_first !== ts + 64'd3) begin
            miscompares++; $display("FAIL late_second got rises %0d cnt %0d at %0d expected 1/3 at %0d", iz_rises, iz_cnt, iz_first, ts + 64'd3); end
        vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL late_done got %0d expected 1", done_cnt); end
    endtask

    task automatic test_zero_cases();
        logic [63:0] ts;
        bit          hit;
        push(model_time + 64'd10, 0, 1'b0, 3, 5, 2, 4, 48'd11);
        observe(30);
        vectors++; if (done_cnt !== 1 || iz_cnt !== 0 || pr_cnt !== 0 || ds_cnt !== 0) begin
            miscompares++; $display("FAIL n0 got done %0d iz %0d pr %0d ds %0d expected 1/0/0/0", done_cnt, iz_cnt, pr_cnt, ds_cnt); end
        ts = model_time + 64'd10;
        push(ts, 1, 1'b0, 2, 3, 0, 2, 48'd12);
        observe(30);
        vectors++; if (iz_first !== ts + 64'd3 || pr_first !== ts + 64'd6 || pr_cnt !== 2) begin
            miscompares++; $display("FAIL tbl2_zero got iz %0d pr %0d prcnt %0d expected %0d/%0d/2", iz_first, pr_first, pr_cnt, ts + 64'd3, ts + 64'd6); end
        push(model_time + 64'd10, 1, 1'b0, 1, 10, 1, 1, 48'd13);
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            tick();
            hit = En_Iz;
        end
        vectors++; if (!hit) begin miscompares++; $display("FAIL abort_iz_timeout got no En_Iz expected En_Iz within 50 cycles"); end
        tick(); tick();
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        vectors++; if (En_Iz !== 1'b0 || DDS_start !== 1'b0 || ABORTED !== 1'b1 || BUSY !== 1'b0 || FIFO_LEVEL !== 3'd0) begin
            miscompares++; $display("FAIL abort_iz got iz %b ds %b aborted %b busy %b level %0d expected 0/0/1/0/0", En_Iz, DDS_start, ABORTED, BUSY, FIFO_LEVEL); end
        observe(20);
        vectors++; if (done_cnt !== 0 || iz_cnt !== 0) begin miscompares++; $display("FAIL abort_quiet got done %0d iz %0d expected 0/0", done_cnt, iz_cnt); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t expected completion", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_time_load();
        test_incoherent();
        test_coherent();
        test_fifo_full_abort();
        test_late();
        test_zero_cases();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
